prog_delay_line: RTL and testbench
==================================

PROG_DELAY_LINE -- requirements
Module: prog_delay_line

Interface
REQ-001 Parameter WIDTH, default 4: number of independent signal channels.
REQ-002 Parameter DEPTH, default 8: number of shift stages, i.e. maximum delay in cycles (legal 2..64).
REQ-003 Parameter DLY_W, default 3: width of delay select, ceil(log2(DEPTH)).
REQ-004 Parameter FILT_LEN, default 3: stability length in cycles for the glitch filter (legal 2..15).
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  reset; synchronous and active-low, sampled on the rising edge of clk.
REQ-007 ce  input  1  clock enable; 1 = shift one sample this cycle.
REQ-008 in_data  input  WIDTH  channel samples entering stage 0.
REQ-009 load  input  1  1 = capture dly_sel into the delay register this cycle.
REQ-010 dly_sel  input  DLY_W  requested tap index; delay = tap+1 cycles.
REQ-011 out_data  output  WIDTH  delayed (optionally filtered) channel values.
REQ-012 out_valid  output  1  1 = out_data reflects real input history, not reset fill.
REQ-013 dly_cur  output  DLY_W  currently applied tap index.

Function
REQ-014 Chain stage[0..DEPTH-1], WIDTH bits each; on a rising edge with ce=1: stage[0]<=in_data, stage[i]<=stage[i-1]; ce=0 holds all stages.
REQ-015 Tap value = stage[dly_cur], combinational from registers; in_data sampled at edge k appears at the tap after edge k+dly_cur (dly_cur+1 enabled edges of latency).
REQ-016 load=1 at an edge sets dly_cur<=min(dly_sel, DEPTH-1); load is independent of ce; chain contents are not disturbed.
REQ-017 Fill counter cnt (0..DEPTH) increments on each edge with ce=1, saturating at DEPTH; it is not cleared by load.
REQ-018 out_valid = (cnt > dly_cur), combinational; raising the delay beyond the filled history drops out_valid until enough samples shift in.
REQ-019 Simultaneous load and ce: shift and tap change both take effect at the same edge; out_valid evaluates new cnt against new dly_cur.
REQ-020 Without the filter (see Configuration), out_data = tap value.
REQ-021 All channels share one delay; channels never interact.

Reset
REQ-022 rst_n=0 at an edge: all stages<=0, cnt<=0, dly_cur<=0, filter state<=0, regardless of ce and load.
REQ-023 After reset: out_data=0, out_valid=0, dly_cur=0.
REQ-024 Reset mid-operation discards all history; first post-reset enabled shift restarts filling from cnt=0.

Configuration
REQ-025 Macro GLITCH_FILTER_EN: when defined, a per-channel filter sits between tap and out_data; when undefined, no filter logic exists and REQ-020 applies.
REQ-026 Filter per channel: register f and counter c (0..FILT_LEN-1); each edge (independent of ce), if tap bit equals f then c<=0; else if c==FILT_LEN-1 then f<=tap bit, c<=0; else c<=c+1.
REQ-027 With the filter, out_data = f; a tap change is passed only after it differs from f on FILT_LEN consecutive edges; shorter pulses are suppressed.
REQ-028 out_valid and dly_cur are identical with and without the filter.

Verification
REQ-029 Reset, ce=1, dly_sel=0 loaded, in_data=4'hA one cycle then 0 -> out_data=4'hA exactly one edge later for one cycle; out_valid=1 after first enabled edge.
REQ-030 load dly_sel=7, stream 0,1,2..15 on channels -> out_valid rises after 8th enabled edge; out_data lags input by 8 edges.
REQ-031 ce toggled 1/0 alternately with dly_cur=3 -> output advances only on ce=1 edges; delay is 4 enabled edges; cnt frozen when ce=0.
REQ-032 After 3 edges filled, load dly_sel=5 -> out_valid falls same cycle, rises after 3 more enabled edges; then load dly_sel=1 -> out_valid stays 1, out_data jumps to stage[1].
REQ-033 GLITCH_FILTER_EN, FILT_LEN=3, dly_cur=0: 2-cycle high pulse on bit0 -> out_data[0] stays 0; 5-cycle pulse -> out_data[0] rises 3 edges after tap rises, falls 3 edges after tap falls.
REQ-034 rst_n=0 asserted mid-stream with load=1, ce=1 -> next cycle out_data=0, out_valid=0, dly_cur=0.

Source files
------------

// File: rtl/prog_delay_line.sv
// prog_delay_line -- programmable multi-channel delay line with an optional
// glitch filter on the output.
//
// All WIDTH channels pass through one shift chain of DEPTH stages. A single
// tap index (dly_cur) selects the stage that drives the output, so the delay
// is dly_cur+1 enabled clock edges. A fill counter tracks how much real input
// history the chain holds. out_valid is high only when the selected tap holds
// a real sample rather than reset fill.
//
// Optional feature: define GLITCH_FILTER_EN to insert a per-channel
// persistence filter between the tap and out_data. A tap change reaches the
// output only after it has held for FILT_LEN consecutive edges. When the
// macro is undefined, no filter logic is built and out_data is the raw tap.
//
// Ports:
//   clk       rising-edge clock for all state
//   rst_n     synchronous active-low reset
//   ce        clock enable; 1 = shift one sample this cycle
//   in_data   [WIDTH] channel samples entering stage 0
//   load      1 = capture dly_sel (clamped to DEPTH-1) into dly_cur
//   dly_sel   [DLY_W] requested tap index
//   out_data  [WIDTH] delayed (optionally filtered) channel values
//   out_valid 1 = out_data reflects real input history
//   dly_cur   [DLY_W] currently applied tap index
module prog_delay_line #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 8,
    parameter int DLY_W    = 3,
    parameter int FILT_LEN = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] in_data,
    input  logic             load,
    input  logic [DLY_W-1:0] dly_sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [DLY_W-1:0] dly_cur
);

    localparam int               CNT_W   = $clog2(DEPTH + 1);
    localparam logic [DLY_W-1:0] MAX_TAP = DLY_W'(DEPTH - 1);

    logic [WIDTH-1:0] stage [DEPTH];
    logic [CNT_W-1:0] cnt;
    logic [DLY_W-1:0] load_tap;
    logic [WIDTH-1:0] tap;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        load_tap = dly_sel;
        if (int'(dly_sel) > DEPTH - 1) begin
            load_tap = MAX_TAP;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so each
    // stage reads its neighbour's pre-edge value and the chain shifts by
    // exactly one position per enabled edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the chain is reset explicitly. Reset must discard all
            // history, and the output path shows the tap value directly.
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
            cnt     <= '0;
            dly_cur <= '0;
        end else begin
            if (ce) begin
                stage[0] <= in_data;
                for (int i = 1; i < DEPTH; i++) begin
                    stage[i] <= stage[i-1];
                end
                if (cnt != CNT_W'(DEPTH)) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
            // Loading is independent of ce and leaves the chain untouched.
            if (load) begin
                dly_cur <= load_tap;
            end
        end
    end

    assign tap       = stage[dly_cur];
    assign out_valid = (int'(cnt) > int'(dly_cur));

`ifdef GLITCH_FILTER_EN
    localparam int FC_W = $clog2(FILT_LEN);

    logic [WIDTH-1:0] filt_q;
    logic [FC_W-1:0]  filt_cnt [WIDTH];

    // The filter runs on every edge, regardless of ce. It counts consecutive
    // edges on which the tap disagrees with the held value. Any agreement
    // restarts the count, which suppresses pulses shorter than FILT_LEN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                filt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (tap[i] == filt_q[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] == FC_W'(FILT_LEN - 1)) begin
                    filt_q[i]   <= tap[i];
                    filt_cnt[i] <= '0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + FC_W'(1);
                end
            end
        end
    end

    assign out_data = filt_q;
`else
    assign out_data = tap;
`endif

endmodule

// File: tb/tb_prog_delay_line.sv
// Self-checking bench for prog_delay_line (default parameters).
// The stimulus process drives one vector per clock. It updates a
// history-based reference model and pushes the expected outputs onto a
// scoreboard queue. A separate monitor pops one entry on each falling edge
// and compares it against the DUT outputs.
module tb_prog_delay_line;

    localparam int WIDTH    = 4;
    localparam int DEPTH    = 8;
    localparam int DLY_W    = 3;
    localparam int FILT_LEN = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ce;
    logic [WIDTH-1:0] in_data;
    logic             load;
    logic [DLY_W-1:0] dly_sel;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [DLY_W-1:0] dly_cur;

    prog_delay_line #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .DLY_W   (DLY_W),
        .FILT_LEN(FILT_LEN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .in_data  (in_data),
        .load     (load),
        .dly_sel  (dly_sel),
        .out_data (out_data),
        .out_valid(out_valid),
        .dly_cur  (dly_cur)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] data;
        logic             valid;
        logic [DLY_W-1:0] dly;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model. hist[0] is the newest enabled sample. Positions beyond
    // the history are reset fill (zero).
    logic [WIDTH-1:0] hist[$];
    int               m_cnt = 0;
    int               m_dly = 0;
    logic [WIDTH-1:0] m_f   = '0;
    int               m_c [WIDTH];

    function automatic logic [WIDTH-1:0] m_tap();
        return (m_dly < hist.size()) ? hist[m_dly] : '0;
    endfunction

    task automatic step(input string tag, input logic rs, input logic c,
                        input logic ld, input int sel, input int d);
        logic [WIDTH-1:0] old_tap;
        exp_t             e;
        rst_n   = rs;
        ce      = c;
        load    = ld;
        dly_sel = DLY_W'(sel);
        in_data = WIDTH'(d);
        @(posedge clk);
        #1;
        old_tap = m_tap();
        if (!rs) begin
            hist.delete();
            m_cnt = 0;
            m_dly = 0;
            m_f   = '0;
            for (int i = 0; i < WIDTH; i++) m_c[i] = 0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (old_tap[i] == m_f[i]) m_c[i] = 0;
                else if (m_c[i] == FILT_LEN - 1) begin
                    m_f[i] = old_tap[i];
                    m_c[i] = 0;
                end else m_c[i] = m_c[i] + 1;
            end
            if (c) begin
                hist.push_front(WIDTH'(d));
                if (hist.size() > DEPTH) void'(hist.pop_back());
                if (m_cnt < DEPTH) m_cnt = m_cnt + 1;
            end
            if (ld) m_dly = (sel > DEPTH - 1) ? DEPTH - 1 : sel;
        end
        e.tag = tag;
`ifdef GLITCH_FILTER_EN
        e.data = m_f;
`else
        e.data = m_tap();
`endif
        e.valid = (m_cnt > m_dly);
        e.dly   = DLY_W'(m_dly);
        sb.push_back(e);
    endtask

    task automatic check(input exp_t e);
        vectors++;
        if (out_data !== e.data || out_valid !== e.valid || dly_cur !== e.dly) begin
            miscompares++;
            $display("FAIL %s: got data=%h valid=%b dly=%0d, expected data=%h valid=%b dly=%0d",
                     e.tag, out_data, out_valid, dly_cur, e.data, e.valid, e.dly);
        end
    endtask

    // Monitor: one expected entry per clock, compared on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) check(sb.pop_front());
        end
    end

    initial begin
        for (int i = 0; i < WIDTH; i++) m_c[i] = 0;

        // Reset state.
        step("reset0", 0, 0, 0, 0, 0);
        step("reset1", 0, 1, 1, 5, 15);

        // Single pulse at delay 0: 4'hA appears one edge later for one cycle.
        step("d0_pulse", 1, 1, 1, 0, 'hA);
        for (int i = 0; i < 3; i++) step("d0_zero", 1, 1, 0, 0, 0);

        // Maximum delay with a counting stream.
        step("rst_a", 0, 0, 0, 0, 0);
        step("d7_load", 1, 0, 1, 7, 0);
        for (int i = 0; i < 16; i++) step("d7_stream", 1, 1, 0, 0, i);
        for (int i = 0; i < 4; i++) step("d7_tail", 1, 1, 0, 0, 15 - i);

        // Alternating ce at tap 3.
        step("rst_b", 0, 0, 0, 0, 0);
        step("d3_load", 1, 0, 1, 3, 0);
        for (int i = 0; i < 16; i++) step("ce_alt", 1, (i % 2) == 0, 0, 0, i + 1);

        // Delay raised beyond the filled history, then lowered.
        step("rst_c", 0, 0, 0, 0, 0);
        step("fill1", 1, 1, 0, 0, 3);
        step("fill2", 1, 1, 0, 0, 5);
        step("fill3", 1, 1, 0, 0, 9);
        step("raise5", 1, 0, 1, 5, 0);
        step("refill1", 1, 1, 0, 0, 12);
        step("refill2", 1, 1, 0, 0, 6);
        step("refill3", 1, 1, 0, 0, 1);
        step("lower1", 1, 0, 1, 1, 0);
        step("hold", 1, 0, 0, 0, 0);

        // Simultaneous load and shift.
        step("ld_ce", 1, 1, 1, 6, 14);
        step("ld_ce2", 1, 1, 1, 2, 4);
        step("ld_ce3", 1, 1, 0, 0, 7);

        // Reset mid-stream with load and ce high.
        step("rst_mid", 0, 1, 1, 4, 11);
        step("post_rst", 1, 1, 0, 0, 2);
        step("post_rst2", 1, 1, 0, 0, 8);

`ifdef GLITCH_FILTER_EN
        // Filter: a 2-cycle pulse is suppressed, a 5-cycle pulse passes.
        step("f_rst", 0, 0, 0, 0, 0);
        step("f_load", 1, 1, 1, 0, 0);
        step("f_p2a", 1, 1, 0, 0, 1);
        step("f_p2b", 1, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) step("f_p2lo", 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("f_p5hi", 1, 1, 0, 0, 1);
        for (int i = 0; i < 6; i++) step("f_p5lo", 1, 1, 0, 0, 0);
`endif

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries never compared, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
